exc_request_ctrl: RTL and testbench
===================================

# exc_request_ctrl

Exception-request controller that drives the `expsrc0`/`expsrc1`/`expsrc2` inputs of `single_cycle_cpu`. It is the requesting end of the CPU's exception interface.
- Synchronises three raw external event lines and latches each rising edge as a pending request.
- Presents at most one prioritised request to the CPU and holds it until the CPU acknowledges.
- Blocks further requests until the handler returns (no nesting).
- Counts taken exceptions and flags events lost because a request was already pending.

## Interface
Parameters:
- `SYNC_STAGES`, 2, synchroniser depth per event line (≥2)
- `CNT_W`, 11, width of the taken-exception counter, matching the CPU's `cnt_*` width

Ports:
- `clk`  input  1  system clock, rising edge
- `reset`  input  1  asynchronous, active-low reset; one clock, no other clock domain
- `ev_in`  input  3  raw event lines, asynchronous to `clk`, active high
- `mask`  input  3  per-source enable; 1 = source may request
- `cpu_ack`  input  1  one-cycle pulse: CPU entered exception handler
- `cpu_eret`  input  1  one-cycle pulse: CPU returned from handler
- `clr_ovf`  input  1  clears `ovf`
- `expsrc0`, `expsrc1`, `expsrc2`  output  1 each  request lines to CPU, one-hot or all zero
- `cause`  output  2  index of the current/last-served source; 3 = none
- `busy`  output  1  high in REQ or SERVICE
- `ovf`  output  3  sticky lost-event flags
- `cnt_taken`  output  `CNT_W`  number of acknowledged exceptions, wraps

## Operation
- Per source: `SYNC_STAGES`-flop synchroniser, then a previous-value register. `edge[i]` = synchronised value 1 and previous value 0.
- `pend[i]` sets on `edge[i]` and clears on `cpu_ack` when `i` is the source being served.
  - If set and clear hit the same source in the same cycle, set wins; `ovf` is not set.
- `edge[i]` while `pend[i]` is already 1 and not being cleared that cycle sets `ovf[i]`. Only `clr_ovf` clears it.
  - If `clr_ovf` and a new overflow occur in the same cycle, set wins.
- Priority: source 0 > source 1 > source 2, selected among `pend & mask`.
- A masked source keeps its pending bit and competes again when unmasked.
- FSM states:
  - IDLE: if any `pend & mask` bit is set, latch the selected index into `sel` and go to REQ.
  - REQ: drive `expsrc[sel]`=1. On `cpu_ack`: clear `pend[sel]`, increment `cnt_taken`, go to SERVICE.
    - A mask change in REQ does not withdraw the request.
  - SERVICE: all `expsrc` = 0. On `cpu_eret`, go to IDLE.
- Ignored inputs:
  - `cpu_ack` outside REQ.
  - `cpu_eret` outside SERVICE.
  - `cpu_eret` in the same cycle as `cpu_ack` in REQ; only the ack is taken.
- `cause` = `sel` in REQ and SERVICE; it keeps the last value in IDLE. It is 3 until the first selection.
- `cnt_taken` wraps from 2^`CNT_W`−1 to 0.

## Timing
- Reset (`reset`=0, asynchronous) values:
  - FSM in IDLE; synchroniser, previous-value and `pend` registers all 0.
  - `expsrc*`=0, `cause`=3, `busy`=0, `ovf`=0, `cnt_taken`=0.
- Reset mid-operation drops any request or service in progress with no handshake. Deassertion takes effect on the next `clk` edge.
- All outputs are registered.
- Latency: `ev_in` first sampled high at edge k (state IDLE, source unmasked, highest priority):
  - `pend` set after edge k+`SYNC_STAGES`.
  - `expsrc` high after edge k+`SYNC_STAGES`+1 (k+3 at the default).
- `cpu_ack` sampled at edge a: `expsrc` low, `cnt_taken`+1 and `pend[sel]` cleared, all after edge a.
- `cpu_eret` at edge e: IDLE after edge e. If a request is pending, the next `expsrc` rises after edge e+1.
- Minimum `ev_in` high and low widths: `SYNC_STAGES`+1 clocks each. Shorter pulses may be missed.

## Structure
- Shared package `exc_pkg` holds:
  - FSM state enum (IDLE, REQ, SERVICE)
  - `CAUSE_NONE`=2'd3
  - source-index constants `SRC0..SRC2`
- One sub-module, `sync_edge_det`: parameterised synchroniser plus rising-edge detector, instantiated three times.
- Top level contains the pending/overflow logic, priority select, FSM and counter.

## Test plan
- Reset, then a single event: pulse `ev_in`=3'b010 for 4 cycles with mask=3'b111 → `expsrc1` rises 3 cycles after sampling; `cause`=1; `busy`=1. `cpu_ack` → `expsrc1`=0, `cnt_taken`=1. `cpu_eret` → `busy`=0.
- Priority and queueing: events 3'b111 in the same cycle → served in order 0, 1, 2 across three ack/eret pairs; `cnt_taken`=3; `ovf`=0.
- Masking: mask=3'b110, event on source 0 → no request. Set mask=3'b111 → `expsrc0` asserts 1 cycle later.
- Lost event: two pulses on source 2 before any ack → `ovf`=3'b100, only one service. `clr_ovf` → `ovf`=0.
- Boundaries:
  - `cpu_ack` in IDLE and `cpu_eret` in REQ → no state change.
  - Ack of source 1 while a new edge on source 1 arrives in the same cycle → `pend[1]` remains 1 and it is served again after eret.
- Reset mid-SERVICE: drive `reset`=0 between clock edges → all outputs reach reset values immediately; `cnt_taken`=0. Preload `cnt_taken` to 2047 → it wraps to 0 on the next ack.

Source files
------------

// File: rtl/exc_request_ctrl_pkg.sv
// Shared types and constants for the exception-request controller.
package exc_pkg;

    // Controller states: waiting, requesting the CPU, CPU inside handler
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] SRC0       = 2'd0;
    localparam logic [1:0] SRC1       = 2'd1;
    localparam logic [1:0] SRC2       = 2'd2;
    localparam logic [1:0] CAUSE_NONE = 2'd3;

    // Fixed priority, source 0 highest; caller guarantees req is non-zero
    function automatic logic [1:0] prioSelect(input logic [2:0] req);
        logic [1:0] idx;
        if (req[0]) begin
            idx = SRC0;
        end else if (req[1]) begin
            idx = SRC1;
        end else begin
            idx = SRC2;
        end
        return idx;
    endfunction

    // Source index to one-hot request vector; CAUSE_NONE maps to all zero
    function automatic logic [2:0] srcOneHot(input logic [1:0] idx);
        logic [2:0] vec;
        case (idx)
            SRC0:    vec = 3'b001;
            SRC1:    vec = 3'b010;
            SRC2:    vec = 3'b100;
            default: vec = 3'b000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/exc_request_ctrl_if.sv
// Handshake between the exception-request controller and the CPU.
interface exc_request_ctrl_if;

    logic       expsrc0;
    logic       expsrc1;
    logic       expsrc2;
    logic [1:0] cause;
    logic       cpu_ack;
    logic       cpu_eret;

    // Requesting side (this controller)
    modport master (
        output expsrc0,
        output expsrc1,
        output expsrc2,
        output cause,
        input  cpu_ack,
        input  cpu_eret
    );

    // Serving side (the CPU)
    modport slave (
        input  expsrc0,
        input  expsrc1,
        input  expsrc2,
        input  cause,
        output cpu_ack,
        output cpu_eret
    );

endinterface

// File: rtl/exc_request_ctrl_sync.sv
// Multi-flop synchroniser for one asynchronous event line followed by a
// rising-edge detector on the synchronised value.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic edge_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the raw line through the synchroniser and remember the last value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign edge_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/exc_request_ctrl.sv
// Exception-request controller: latches synchronised event edges as pending
// requests, presents one prioritised request to the CPU at a time, waits for
// the handler to return, counts taken exceptions and flags lost events.
module exc_request_ctrl
    import exc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       ev_in,
    input  logic [2:0]       mask,
    input  logic             clr_ovf,
    exc_request_ctrl_if.master cpu,
    output logic             busy,
    output logic [2:0]       ovf,
    output logic [CNT_W-1:0] cnt_taken
);

    logic [2:0]       edgeDet;
    logic [2:0]       pend_q,   pend_d;
    logic [2:0]       ovf_q,    ovf_d;
    logic [2:0]       expsrc_q, expsrc_d;
    logic [1:0]       sel_q,    sel_d;
    logic             busy_q,   busy_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    state_t           state_q,  state_d;
    logic             ackTake;
    logic [2:0]       clrVec;
    logic [2:0]       eligible;

    for (genvar i = 0; i < 3; i++) begin : g_sync
        sync_edge_det #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk     (clk),
            .reset   (reset),
            .async_i (ev_in[i]),
            .edge_o  (edgeDet[i])
        );
    end

    assign eligible = pend_q & mask;

    // Next state, selection latch and registered request lines
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        ackTake  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    sel_d   = prioSelect(eligible);
                    state_d = REQ;
                end
            end
            REQ: begin
                if (cpu.cpu_ack) begin
                    ackTake = 1'b1;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (cpu.cpu_eret) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        expsrc_d = (state_d == REQ) ? srcOneHot(sel_d) : 3'b000;
        busy_d   = (state_d != IDLE);
    end

    // Pending set wins over the clear of the served source; a new edge on a
    // still-pending source is a lost event unless that source is cleared now
    always_comb begin
        clrVec = ackTake ? srcOneHot(sel_q) : 3'b000;
        pend_d = (pend_q & ~clrVec) | edgeDet;
        ovf_d  = (clr_ovf ? 3'b000 : ovf_q) | (edgeDet & pend_q & ~clrVec);
        cnt_d  = ackTake ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Controller state and all output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sel_q    <= CAUSE_NONE;
            pend_q   <= 3'b000;
            ovf_q    <= 3'b000;
            expsrc_q <= 3'b000;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            expsrc_q <= expsrc_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cpu.expsrc0 = expsrc_q[0];
    assign cpu.expsrc1 = expsrc_q[1];
    assign cpu.expsrc2 = expsrc_q[2];
    assign cpu.cause   = sel_q;
    assign busy        = busy_q;
    assign ovf         = ovf_q;
    assign cnt_taken   = cnt_q;

endmodule

// File: tb/tb_exc_request_ctrl.sv
// Self-checking bench for exc_request_ctrl with a scoreboard of expected causes.
module tb_exc_request_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  ev_in;
    logic [2:0]  mask;
    logic        clr_ovf;
    logic        busy;
    logic [2:0]  ovf;
    logic [10:0] cnt_taken;

    int testsRun  = 0;
    int failCount = 0;
    int expQ[$];
    int expCnt    = 0;

    exc_request_ctrl_if cpuIf ();

    exc_request_ctrl #(
        .SYNC_STAGES (2),
        .CNT_W       (11)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ev_in     (ev_in),
        .mask      (mask),
        .clr_ovf   (clr_ovf),
        .cpu       (cpuIf),
        .busy      (busy),
        .ovf       (ovf),
        .cnt_taken (cnt_taken)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] expsrcVec();
        return {cpuIf.expsrc2, cpuIf.expsrc1, cpuIf.expsrc0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive an event pattern high then low for the given widths
    task automatic applyStimulus(input logic [2:0] vec, input int hi, input int lo);
        ev_in = vec;
        tick(hi);
        ev_in = 3'b000;
        tick(lo);
    endtask

    // Wait (bounded) for a request and compare it with the scoreboard head
    task automatic waitReq();
        int  expCause;
        bit  seen;
        seen = 0;
        expCause = 3;
        if (expQ.size() > 0) expCause = expQ.pop_front();
        else checkOutput("sb_empty", 32'd0, 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (expsrcVec() != 3'b000) begin
                seen = 1;
                break;
            end
            tick(1);
        end
        if (!seen) checkOutput("req_timeout", 32'd0, 32'd1);
        checkOutput("req_cause", 32'(cpuIf.cause), 32'(expCause));
        checkOutput("req_expsrc", 32'(expsrcVec()), 32'(3'b001 << expCause));
        checkOutput("req_busy", 32'(busy), 32'd1);
    endtask

    task automatic serveAck();
        cpuIf.cpu_ack = 1'b1;
        tick(1);
        cpuIf.cpu_ack = 1'b0;
        expCnt = (expCnt + 1) & 32'h7FF;
        checkOutput("ack_expsrc", 32'(expsrcVec()), 32'd0);
        checkOutput("ack_cnt", 32'(cnt_taken), 32'(expCnt));
    endtask

    task automatic serveEret();
        cpuIf.cpu_eret = 1'b1;
        tick(1);
        cpuIf.cpu_eret = 1'b0;
        checkOutput("eret_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        reset          = 1'b0;
        ev_in          = 3'b000;
        mask           = 3'b111;
        clr_ovf        = 1'b0;
        cpuIf.cpu_ack  = 1'b0;
        cpuIf.cpu_eret = 1'b0;
        tick(3);
        checkOutput("rst_expsrc", 32'(expsrcVec()), 32'd0);
        checkOutput("rst_cause", 32'(cpuIf.cause), 32'd3);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_cnt", 32'(cnt_taken), 32'd0);
        reset = 1'b1;
        tick(2);

        // Single event on source 1 with latency check
        expQ.push_back(1);
        ev_in = 3'b010;
        tick(3);
        checkOutput("lat_early", 32'(cpuIf.expsrc1), 32'd0);
        tick(1);
        checkOutput("lat_exact", 32'(cpuIf.expsrc1), 32'd1);
        waitReq();
        ev_in = 3'b000;
        tick(3);
        serveAck();
        serveEret();

        // Simultaneous events served in priority order
        expQ.push_back(0);
        expQ.push_back(1);
        expQ.push_back(2);
        applyStimulus(3'b111, 4, 4);
        for (int s = 0; s < 3; s++) begin
            waitReq();
            serveAck();
            serveEret();
        end
        checkOutput("prio_ovf", 32'(ovf), 32'd0);

        // Masked source stays pending and requests once unmasked
        mask = 3'b110;
        applyStimulus(3'b001, 4, 4);
        tick(2);
        checkOutput("mask_expsrc", 32'(expsrcVec()), 32'd0);
        checkOutput("mask_busy", 32'(busy), 32'd0);
        mask = 3'b111;
        expQ.push_back(0);
        tick(1);
        checkOutput("unmask_expsrc0", 32'(cpuIf.expsrc0), 32'd1);
        waitReq();
        serveAck();
        serveEret();

        // Lost event on source 2
        expQ.push_back(2);
        applyStimulus(3'b100, 4, 4);
        applyStimulus(3'b100, 4, 4);
        checkOutput("lost_ovf", 32'(ovf), 32'h4);
        waitReq();
        serveAck();
        serveEret();
        tick(6);
        checkOutput("lost_single", 32'(busy), 32'd0);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        checkOutput("clr_ovf", 32'(ovf), 32'd0);

        // Ack in IDLE and eret in REQ are ignored
        cpuIf.cpu_ack = 1'b1;
        tick(1);
        cpuIf.cpu_ack = 1'b0;
        checkOutput("idle_ack_busy", 32'(busy), 32'd0);
        checkOutput("idle_ack_cnt", 32'(cnt_taken), 32'(expCnt));
        expQ.push_back(1);
        applyStimulus(3'b010, 4, 4);
        waitReq();
        cpuIf.cpu_eret = 1'b1;
        tick(1);
        cpuIf.cpu_eret = 1'b0;
        checkOutput("req_eret_busy", 32'(busy), 32'd1);
        checkOutput("req_eret_expsrc", 32'(expsrcVec()), 32'h2);

        // Ack of source 1 coinciding with a new edge on source 1
        ev_in = 3'b010;
        tick(2);
        cpuIf.cpu_ack = 1'b1;
        tick(1);
        cpuIf.cpu_ack = 1'b0;
        expCnt = (expCnt + 1) & 32'h7FF;
        checkOutput("coll_expsrc", 32'(expsrcVec()), 32'd0);
        checkOutput("coll_ovf", 32'(ovf), 32'd0);
        checkOutput("coll_cnt", 32'(cnt_taken), 32'(expCnt));
        ev_in = 3'b000;
        expQ.push_back(1);
        tick(3);
        serveEret();
        waitReq();

        // Ack and eret together: only the ack is taken
        cpuIf.cpu_ack  = 1'b1;
        cpuIf.cpu_eret = 1'b1;
        tick(1);
        cpuIf.cpu_ack  = 1'b0;
        cpuIf.cpu_eret = 1'b0;
        expCnt = (expCnt + 1) & 32'h7FF;
        checkOutput("ackeret_busy", 32'(busy), 32'd1);
        checkOutput("ackeret_cnt", 32'(cnt_taken), 32'(expCnt));
        serveEret();

        // Asynchronous reset in the middle of SERVICE
        expQ.push_back(0);
        applyStimulus(3'b001, 4, 4);
        applyStimulus(3'b001, 4, 4);
        checkOutput("pre_rst_ovf", 32'(ovf), 32'h1);
        waitReq();
        serveAck();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_expsrc", 32'(expsrcVec()), 32'd0);
        checkOutput("arst_cause", 32'(cpuIf.cause), 32'd3);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_ovf", 32'(ovf), 32'd0);
        checkOutput("arst_cnt", 32'(cnt_taken), 32'd0);
        tick(2);
        reset  = 1'b1;
        expCnt = 0;
        tick(2);

        // Counter wrap from 2047 to 0
        for (int i = 0; i < 2048; i++) begin
            expQ.push_back(0);
            applyStimulus(3'b001, 3, 3);
            waitReq();
            serveAck();
            serveEret();
            if (i == 2046) checkOutput("cnt_max", 32'(cnt_taken), 32'd2047);
        end
        checkOutput("cnt_wrap", 32'(cnt_taken), 32'd0);
        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
